// File: rtl/mm_pkg.sv
// Shared MiniMicro definitions: sequencer state encoding and the default
// program-counter width used by the fetch sequencer and its PC register.
package mm_pkg;

  localparam int unsigned DEFAULT_PC_W = 6;
  localparam int unsigned STATE_W      = 3;

  // Encodings are fixed because the state is exported on a debug port.
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALTED  = 3'd4,
    FAULT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register.
// Ports:
//   clk       rising-edge clock
//   clr_n     synchronous active-low clear (pc -> 0)
//   inc_en    pc <= pc + 1 (wraps modulo 2^W)
//   load_en   pc <= load_val (has priority over inc_en)
//   load_val  parallel load value
//   pc        current register value
module pc_reg
  import mm_pkg::*;
#(
  parameter int unsigned W = DEFAULT_PC_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc_en,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  // Load beats increment; natural overflow gives the address wrap.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning the program counter.
// Optional feature: define FETCH_TIMEOUT_EN to enable the fetch watchdog
// (TIMEOUT un-acked FETCH cycles -> FAULT, left only by reset).
// Ports:
//   clk, rst (sync, active-low)
//   start, halt_req, imem_ack, exec_done, is_halt,
//   branch_taken, branch_target          : control inputs
//   pc            current instruction address (imem address)
//   imem_req      fetch request (FETCH state)
//   ir_load       capture instruction word (FETCH and imem_ack, combinational)
//   dec_valid     decoder output valid (DECODE state)
//   halted        sequencer halted
//   fault         fetch watchdog tripped (0 without FETCH_TIMEOUT_EN)
//   state         encoded FSM state for debug
module fetch_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned PC_W    = DEFAULT_PC_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  input  logic            imem_ack,
  input  logic            exec_done,
  input  logic            is_halt,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            ir_load,
  output logic            dec_valid,
  output logic            halted,
  output logic            fault,
  output logic [2:0]      state
);

  seq_state_t state_q;
  seq_state_t state_d;
  logic       pc_inc;
  logic       pc_load;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_cnt_d;

  // Consecutive un-acked FETCH cycles already completed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  pc_reg #(.W(PC_W)) u_pc_reg (
    .clk      (clk),
    .clr_n    (rst),
    .inc_en   (pc_inc),
    .load_en  (pc_load),
    .load_val (branch_target),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, PC control and the single Mealy output ir_load.
  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    ir_load = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wd_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        ir_load = imem_ack;
        if (imem_ack) begin
          state_d = DECODE;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          // This cycle is the TIMEOUT-th without ack; an ack here would win.
          if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = FAULT;
          end else begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      DECODE: begin
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (exec_done) begin
          // HALT keeps pc on the HALT instruction and discards any branch.
          if (is_halt) begin
            state_d = HALTED;
          end else begin
            pc_load = branch_taken;
            pc_inc  = !branch_taken;
            state_d = halt_req ? HALTED : FETCH;
          end
        end
      end
      HALTED: begin
        if (start) state_d = FETCH;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req  = (state_q == FETCH);
  assign dec_valid = (state_q == DECODE);
  assign halted    = (state_q == HALTED);
`ifdef FETCH_TIMEOUT_EN
  assign fault     = (state_q == FAULT);
`else
  assign fault     = 1'b0;
`endif
  assign state     = 3'(state_q);

endmodule
